// File: rtl/rgb_fade_sequencer.sv
// Colour-table crossfade sequencer that drives the RGB PWM duty inputs; outputs are registered and move by one step per tick.
// stop freezes the colour in IDLE, and cfg_we updates the colour table in any state.
module rgb_fade_sequencer #(
   parameter int TICK_DIV   = 1000000,
   parameter int HOLD_TICKS = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        stop,
   input  logic [1:0]  last_idx,
   input  logic        cfg_we,
   input  logic [1:0]  cfg_addr,
   input  logic [23:0] cfg_data,
   output logic [7:0]  R_time_out,
   output logic [7:0]  G_time_out,
   output logic [7:0]  B_time_out,
   output logic [1:0]  cur_idx,
   output logic        busy,
   output logic        seq_wrap
);

   localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_FADE, S_HOLD} state_t;

   state_t          r_state;
   logic [23:0]     r_tab [4];
   logic [7:0]      r_r;
   logic [7:0]      r_g;
   logic [7:0]      r_b;
   logic [1:0]      r_cur_idx;
   logic            r_seq_wrap;
   logic [TW-1:0]   r_tick_cnt;
   logic [HW-1:0]   r_hold_cnt;

   logic [23:0]     w_tgt;
   logic            w_tick;
   logic            w_at_tgt;

   function automatic logic [7:0] f_step(input logic [7:0] cur, input logic [7:0] tgt);
      if (cur < tgt)
         return cur + 8'd1;
      else if (cur > tgt)
         return cur - 8'd1;
      else
         return cur;
   endfunction

   // The target is read live, so a table write to the current entry retargets the fade.
   assign w_tgt    = r_tab[r_cur_idx];
   assign w_at_tgt = ({r_r, r_g, r_b} == w_tgt);
   assign w_tick   = (r_state != S_IDLE) && (r_tick_cnt == TW'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_tab[0]   <= 24'hFF0000;
         r_tab[1]   <= 24'h00FF00;
         r_tab[2]   <= 24'h0000FF;
         r_tab[3]   <= 24'h000000;
         r_r        <= 8'd0;
         r_g        <= 8'd0;
         r_b        <= 8'd0;
         r_cur_idx  <= 2'd0;
         r_seq_wrap <= 1'b0;
         r_tick_cnt <= '0;
         r_hold_cnt <= '0;
      end else begin
         if (cfg_we)
            r_tab[cfg_addr] <= cfg_data;
         r_seq_wrap <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_tick_cnt <= '0;
               if (start && !stop) begin
                  r_state    <= S_FADE;
                  r_cur_idx  <= 2'd0;
                  r_hold_cnt <= '0;
               end
            end
            S_FADE, S_HOLD: begin
               if (stop) begin
                  r_state    <= S_IDLE;
                  r_tick_cnt <= '0;
                  r_hold_cnt <= '0;
               end else begin
                  r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
                  if (w_tick && r_state == S_FADE) begin
                     if (w_at_tgt) begin
                        r_state    <= S_HOLD;
                        r_hold_cnt <= '0;
                     end else begin
                        r_r <= f_step(r_r, w_tgt[23:16]);
                        r_g <= f_step(r_g, w_tgt[15:8]);
                        r_b <= f_step(r_b, w_tgt[7:0]);
                     end
                  end else if (w_tick) begin
                     if (r_hold_cnt == HW'(HOLD_TICKS - 1)) begin
                        r_state    <= S_FADE;
                        r_hold_cnt <= '0;
                        // >= so that lowering last_idx mid-run still wraps.
                        if (r_cur_idx >= last_idx) begin
                           r_cur_idx  <= 2'd0;
                           r_seq_wrap <= 1'b1;
                        end else begin
                           r_cur_idx <= r_cur_idx + 2'd1;
                        end
                     end else begin
                        r_hold_cnt <= r_hold_cnt + HW'(1);
                     end
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign R_time_out = r_r;
   assign G_time_out = r_g;
   assign B_time_out = r_b;
   assign cur_idx    = r_cur_idx;
   assign seq_wrap   = r_seq_wrap;
   assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Bench for rgb_fade_sequencer: directed scenarios plus random colour tables checked against a tick-trajectory model.
module tb_rgb_fade_sequencer;
   localparam int TD = 4;
   localparam int HT = 2;
   localparam int NT = 36;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        stop;
   logic [1:0]  last_idx;
   logic        cfg_we;
   logic [1:0]  cfg_addr;
   logic [23:0] cfg_data;
   logic [7:0]  r_out;
   logic [7:0]  g_out;
   logic [7:0]  b_out;
   logic [1:0]  cur_idx;
   logic        busy;
   logic        seq_wrap;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [23:0] m_tab [4];
   logic [23:0] m_col;
   logic [26:0] exp_q [$];

   wire [26:0] obs = {r_out, g_out, b_out, cur_idx, seq_wrap};

   always #5 clk = ~clk;

   rgb_fade_sequencer #(.TICK_DIV(TD), .HOLD_TICKS(HT)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .last_idx(last_idx),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .R_time_out(r_out), .G_time_out(g_out), .B_time_out(b_out),
      .cur_idx(cur_idx), .busy(busy), .seq_wrap(seq_wrap)
   );

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [23:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
      cyc(1);
      cfg_we = 1'b0;
      m_tab[a] = d;
   endtask

   task automatic pulse_start();
      start = 1'b1; cyc(1); start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1; cyc(1); stop = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; cyc(2); rst = 1'b0;
      m_tab[0] = 24'hFF0000; m_tab[1] = 24'h00FF00;
      m_tab[2] = 24'h0000FF; m_tab[3] = 24'h000000;
      m_col = 24'h0;
   endtask

   function automatic logic [7:0] toward(input logic [7:0] a, input logic [7:0] t);
      if (a < t) return a + 8'd1;
      if (a > t) return a - 8'd1;
      return a;
   endfunction

   // Expected {colour, idx, wrap} after each tick: walk each entry, one detect tick, HT hold ticks.
   task automatic build_traj(input logic [23:0] c0, input int last, input int n);
      logic [23:0] c;
      logic [23:0] tgt;
      int          idx;
      logic        w;
      c = c0; idx = 0; exp_q.delete();
      while (exp_q.size() < n) begin
         tgt = m_tab[idx];
         while (c !== tgt) begin
            c = {toward(c[23:16], tgt[23:16]), toward(c[15:8], tgt[15:8]), toward(c[7:0], tgt[7:0])};
            exp_q.push_back({c, 2'(idx), 1'b0});
         end
         for (int h = 0; h <= HT; h++) begin
            if (h == HT) begin
               w = (idx >= last);
               idx = w ? 0 : idx + 1;
               exp_q.push_back({c, 2'(idx), w});
            end else begin
               exp_q.push_back({c, 2'(idx), 1'b0});
            end
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 20; i++) begin
         n_tests++;
         if ({obs, busy} !== 28'd0) begin
            n_fail++;
            $display("FAIL reset_idle cyc%0d: got %h expected %h", i, {obs, busy}, 28'd0);
         end
         cyc(1);
      end
   endtask

   task automatic test_fade_basic();
      logic [23:0] cols [3];
      logic [23:0] prev;
      logic [26:0] e;
      cols[0] = 24'h010101; cols[1] = 24'h020201; cols[2] = 24'h030201;
      cfg_write(2'd0, 24'h030201);
      last_idx = 2'd0;
      pulse_start();
      n_tests++;
      if (busy !== 1'b1) begin
         n_fail++; $display("FAIL basic_busy: got %b expected 1", busy);
      end
      prev = 24'h0;
      for (int t = 1; t <= 9; t++) begin
         cyc(TD - 1);
         n_tests++;
         if (obs !== {prev, 2'd0, 1'b0}) begin
            n_fail++; $display("FAIL basic_between t%0d: got %h expected %h", t, obs, {prev, 2'd0, 1'b0});
         end
         cyc(1);
         e = {(t <= 3) ? cols[t-1] : 24'h030201, 2'd0, (t == 6 || t == 9)};
         n_tests++;
         if (obs !== e) begin
            n_fail++; $display("FAIL basic_tick t%0d: got %h expected %h", t, obs, e);
         end
         prev = e[26:3];
      end
      cyc(1);
      n_tests++;
      if (seq_wrap !== 1'b0) begin
         n_fail++; $display("FAIL basic_wrap_pulse: got %b expected 0", seq_wrap);
      end
      pulse_stop();
      m_col = 24'h030201;
   endtask

   task automatic test_model_runs();
      int          last;
      logic [26:0] prev;
      for (int rnd = 0; rnd < 6; rnd++) begin
         if (rnd == 0) begin
            cfg_write(2'd0, 24'h030201);
            cfg_write(2'd1, 24'h010005);
            last = 1;
         end else begin
            for (int a = 0; a < 4; a++)
               cfg_write(2'(a), {8'($urandom_range(0, 24)), 8'($urandom_range(0, 24)), 8'($urandom_range(0, 24))});
            last = $urandom_range(0, 3);
         end
         last_idx = 2'(last);
         build_traj(m_col, last, NT);
         pulse_start();
         n_tests++;
         if (busy !== 1'b1) begin
            n_fail++; $display("FAIL model_busy r%0d: got %b expected 1", rnd, busy);
         end
         prev = {m_col, 2'd0, 1'b0};
         for (int t = 0; t < NT; t++) begin
            cyc(TD - 1);
            n_tests++;
            if (obs !== prev) begin
               n_fail++; $display("FAIL model_between r%0d t%0d: got %h expected %h", rnd, t, obs, prev);
            end
            cyc(1);
            n_tests++;
            if (obs !== exp_q[t]) begin
               n_fail++; $display("FAIL model_tick r%0d t%0d: got %h expected %h", rnd, t, obs, exp_q[t]);
            end
            prev = {exp_q[t][26:1], 1'b0};
         end
         pulse_stop();
         m_col = exp_q[NT-1][26:3];
         n_tests++;
         if (busy !== 1'b0) begin
            n_fail++; $display("FAIL model_stop r%0d: got busy %b expected 0", rnd, busy);
         end
      end
   endtask

   task automatic test_stop_resume();
      do_reset();
      cfg_write(2'd0, 24'h050505);
      last_idx = 2'd0;
      pulse_start();
      cyc(TD);
      n_tests++;
      if (obs !== {24'h010101, 3'b0}) begin
         n_fail++; $display("FAIL stop_tick1: got %h expected %h", obs, {24'h010101, 3'b0});
      end
      cyc(TD);
      n_tests++;
      if (obs !== {24'h020202, 3'b0}) begin
         n_fail++; $display("FAIL stop_tick2: got %h expected %h", obs, {24'h020202, 3'b0});
      end
      cyc(2);
      pulse_stop();
      for (int i = 0; i < 50; i++) begin
         n_tests++;
         if ({obs, busy} !== {24'h020202, 4'b0}) begin
            n_fail++; $display("FAIL stop_frozen c%0d: got %h expected %h", i, {obs, busy}, {24'h020202, 4'b0});
         end
         cyc(1);
      end
      pulse_start();
      cyc(TD - 1);
      n_tests++;
      if ({obs, busy} !== {24'h020202, 4'b0001}) begin
         n_fail++; $display("FAIL resume_pre: got %h expected %h", {obs, busy}, {24'h020202, 4'b0001});
      end
      cyc(1);
      n_tests++;
      if (obs !== {24'h030303, 3'b0}) begin
         n_fail++; $display("FAIL resume_tick: got %h expected %h", obs, {24'h030303, 3'b0});
      end
   endtask

   task automatic test_start_stop_retarget();
      pulse_stop();
      start = 1'b1; stop = 1'b1;
      cyc(1);
      start = 1'b0; stop = 1'b0;
      cyc(TD - 1);
      n_tests++;
      if ({obs, busy} !== {24'h030303, 4'b0}) begin
         n_fail++; $display("FAIL start_stop_idle: got %h expected %h", {obs, busy}, {24'h030303, 4'b0});
      end
      pulse_start();
      cyc(TD);
      n_tests++;
      if ({obs, busy} !== {24'h040404, 4'b0001}) begin
         n_fail++; $display("FAIL retarget_pre: got %h expected %h", {obs, busy}, {24'h040404, 4'b0001});
      end
      cfg_write(2'd0, 24'h000000);
      cyc(TD - 1);
      n_tests++;
      if (obs !== {24'h030303, 3'b0}) begin
         n_fail++; $display("FAIL retarget_t1: got %h expected %h", obs, {24'h030303, 3'b0});
      end
      cyc(TD);
      n_tests++;
      if ({obs, busy} !== {24'h020202, 4'b0001}) begin
         n_fail++; $display("FAIL retarget_t2: got %h expected %h", {obs, busy}, {24'h020202, 4'b0001});
      end
   endtask

   task automatic test_reset_mid_hold();
      cfg_write(2'd0, 24'h020202);
      cyc(TD - 1);
      cyc(1);
      n_tests++;
      if ({obs, busy} !== {24'h020202, 4'b0001}) begin
         n_fail++; $display("FAIL hold_pre: got %h expected %h", {obs, busy}, {24'h020202, 4'b0001});
      end
      rst = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 24'h123456;
      cyc(1);
      rst = 1'b0; cfg_we = 1'b0;
      n_tests++;
      if ({obs, busy} !== 28'd0) begin
         n_fail++; $display("FAIL rst_mid_hold: got %h expected %h", {obs, busy}, 28'd0);
      end
      last_idx = 2'd0;
      pulse_start();
      cyc(TD);
      n_tests++;
      if (obs !== {24'h010000, 3'b0}) begin
         n_fail++; $display("FAIL rst_default_e0: got %h expected %h", obs, {24'h010000, 3'b0});
      end
      cyc(TD * 254);
      n_tests++;
      if (obs !== {24'hFF0000, 3'b0}) begin
         n_fail++; $display("FAIL sat_reach: got %h expected %h", obs, {24'hFF0000, 3'b0});
      end
      cyc(TD * 3);
      n_tests++;
      if (obs !== {24'hFF0000, 3'b001}) begin
         n_fail++; $display("FAIL sat_wrap: got %h expected %h", obs, {24'hFF0000, 3'b001});
      end
      cyc(TD * 2);
      n_tests++;
      if (obs !== {24'hFF0000, 3'b0}) begin
         n_fail++; $display("FAIL sat_hold: got %h expected %h", obs, {24'hFF0000, 3'b0});
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; last_idx = 2'd0;
      cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data = 24'h0;
      test_reset();
      test_fade_basic();
      test_model_runs();
      test_stop_resume();
      test_start_stop_retarget();
      test_reset_mid_hold();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
